// File: rtl/vga_fb_arbiter_if.sv
// Writer-side request/acknowledge bundle for the framebuffer arbiter.
// The master drives a held request; the slave returns a one-cycle ack and error pulse.
interface vga_fb_arbiter_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
);
    logic              iWrReq;
    logic [ADDR_W-1:0] iWrAddr;
    logic [DATA_W-1:0] iWrData;
    logic              oWrAck;
    logic              oWrErr;

    modport master (
        output iWrReq, iWrAddr, iWrData,
        input  oWrAck, oWrErr
    );

    modport slave (
        input  iWrReq, iWrAddr, iWrData,
        output oWrAck, oWrErr
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port cell framebuffer arbiter: fixed display fetch slots, writer granted in the gaps.
// Optional macro VGA_FB_BLANK_WRITE_EN restricts writes to vertical blanking.
module vga_fb_arbiter #(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned CELL_SHIFT = 3,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 13
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [9:0]        iCountH,
    input  logic [9:0]        iCountV,
    vga_fb_arbiter_if.slave   wr,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemWe,
    output logic [DATA_W-1:0] oMemWData,
    input  logic [DATA_W-1:0] iMemRData,
    output logic [DATA_W-1:0] oPixel
);

    localparam int unsigned COLS   = WIDTH >> CELL_SHIFT;
    localparam int unsigned NCELLS = COLS * (HEIGHT >> CELL_SHIFT);

    localparam logic [9:0]        WIDTH_C  = 10'(WIDTH);
    localparam logic [9:0]        HEIGHT_C = 10'(HEIGHT);
    localparam logic [ADDR_W-1:0] COLS_C   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] NCELLS_C = ADDR_W'(NCELLS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;
    logic              active_d1_q, active_d2_q;
    logic              slot_d1_q, slot_d2_q;
    logic [DATA_W-1:0] pixel_q, pixel_d;

    logic              active_c;
    logic              slot_c;
    logic              blank_ok_c;
    logic              grant_c;
    logic [ADDR_W-1:0] slot_addr_c;

    assign active_c    = (iCountH < WIDTH_C) && (iCountV < HEIGHT_C);
    assign slot_c      = active_c && (iCountH[CELL_SHIFT-1:0] == '0);
    assign slot_addr_c = ADDR_W'(iCountV >> CELL_SHIFT) * COLS_C
                       + ADDR_W'(iCountH >> CELL_SHIFT);

`ifdef VGA_FB_BLANK_WRITE_EN
    assign blank_ok_c = (iCountV >= HEIGHT_C);
`else
    assign blank_ok_c = 1'b1;
`endif

    assign grant_c = wr.iWrReq && !slot_c && blank_ok_c;

    // Next-state: display slot wins the port, otherwise an idle FSM may take a write.
    always_comb begin
        state_d     = ST_IDLE;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_ack_d    = 1'b0;
        wr_err_d    = 1'b0;
        if (slot_c) begin
            mem_addr_d = slot_addr_c;
        end else if ((state_q == ST_IDLE) && grant_c) begin
            state_d    = ST_WRITE;
            mem_addr_d = wr.iWrAddr;
            wr_ack_d   = 1'b1;
            if (wr.iWrAddr < NCELLS_C) begin
                mem_we_d    = 1'b1;
                mem_wdata_d = wr.iWrData;
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    // Pixel capture lines up with read data two cycles after the slot address.
    always_comb begin
        pixel_d = pixel_q;
        if (!active_d2_q) begin
            pixel_d = '0;
        end else if (slot_d2_q) begin
            pixel_d = iMemRData;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            active_d1_q <= 1'b0;
            active_d2_q <= 1'b0;
            slot_d1_q   <= 1'b0;
            slot_d2_q   <= 1'b0;
            pixel_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
            active_d1_q <= active_c;
            active_d2_q <= active_d1_q;
            slot_d1_q   <= slot_c;
            slot_d2_q   <= slot_d1_q;
            pixel_q     <= pixel_d;
        end
    end

    assign oMemAddr  = mem_addr_q;
    assign oMemWe    = mem_we_q;
    assign oMemWData = mem_wdata_q;
    assign wr.oWrAck = wr_ack_q;
    assign wr.oWrErr = wr_err_q;
    assign oPixel    = pixel_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: directed counter/request vectors, an ack queue
// and a cycle-stamped check queue drained by a negedge monitor, plus a framebuffer model.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  cnt_h, cnt_v;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata, pixel;
    int          cyc = 0;
    int          cmp_cnt = 0;
    int          mis_cnt = 0;

    vga_fb_arbiter_if #(.ADDR_W(13), .DATA_W(8)) wr_if ();

    vga_fb_arbiter dut (
        .iClk     (clk),
        .iRst     (rst),
        .iCountH  (cnt_h),
        .iCountV  (cnt_v),
        .wr       (wr_if),
        .oMemAddr (mem_addr),
        .oMemWe   (mem_we),
        .oMemWData(mem_wdata),
        .iMemRData(mem_rdata),
        .oPixel   (pixel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port framebuffer model.
    logic [7:0] mem [0:8191];
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
        mem[82] <= 8'h1C;
        mem[83] <= 8'h55;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct { logic [12:0] addr; logic we; logic [7:0] data; logic err; } ack_t;
    typedef struct { int cyc; int sig; logic [15:0] exp; } chk_t;
    ack_t ack_q[$];
    chk_t chk_q[$];

    function automatic void cmp(string name, int at, logic [15:0] act, logic [15:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, at, act, exp);
        end
    endfunction

    function automatic logic [15:0] sig_val(int s);
        case (s)
            0:       return 16'(wr_if.oWrAck);
            1:       return 16'(wr_if.oWrErr);
            2:       return 16'(mem_we);
            3:       return 16'(mem_addr);
            4:       return 16'(mem_wdata);
            default: return 16'(pixel);
        endcase
    endfunction

    function automatic string sig_name(int s);
        case (s)
            0:       return "ack";
            1:       return "err";
            2:       return "mem_we";
            3:       return "mem_addr";
            4:       return "mem_wdata";
            default: return "pixel";
        endcase
    endfunction

    // Monitor: stamped checks for this cycle, and every ack pulse against the ack queue.
    always @(negedge clk) begin
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].cyc == cyc) begin
                cmp(sig_name(chk_q[i].sig), cyc, sig_val(chk_q[i].sig), chk_q[i].exp);
                chk_q.delete(i);
            end
        end
        if (wr_if.oWrAck === 1'b1) begin
            if (ack_q.size() == 0) begin
                cmp("unexpected_ack", cyc, 16'd1, 16'd0);
            end else begin
                ack_t e;
                e = ack_q.pop_front();
                cmp("ack_addr", cyc, 16'(mem_addr), 16'(e.addr));
                cmp("ack_we",   cyc, 16'(mem_we),   16'(e.we));
                cmp("ack_err",  cyc, 16'(wr_if.oWrErr), 16'(e.err));
                if (e.we) cmp("ack_wdata", cyc, 16'(mem_wdata), 16'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(int c, int s, int v);
        chk_t k;
        k.cyc = c; k.sig = s; k.exp = 16'(v);
        chk_q.push_back(k);
    endtask

    task automatic expect_ack(int a, bit we, int d, bit err);
        ack_t e;
        e.addr = 13'(a); e.we = we; e.data = 8'(d); e.err = err;
        ack_q.push_back(e);
    endtask

    task automatic blank();
        cnt_h = 10'd700;
        cnt_v = 10'd500;
    endtask

    task automatic request(int a, int d);
        wr_if.iWrReq  = 1'b1;
        wr_if.iWrAddr = 13'(a);
        wr_if.iWrData = 8'(d);
    endtask

    int t;

    initial begin
        rst = 1'b1;
        blank();
        wr_if.iWrReq  = 1'b0;
        wr_if.iWrAddr = '0;
        wr_if.iWrData = '0;

        // Reset values
        @(negedge clk);
        for (int s = 0; s < 6; s++) cmp({"rst_", sig_name(s)}, cyc, sig_val(s), 16'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Blanking write: ack one cycle after request, then back to idle
        tick(); t = cyc;
        request(0, 'hE0);
        expect_ack(0, 1'b1, 'hE0, 1'b0);
        expect_at(t + 1, 0, 1);
        expect_at(t + 2, 0, 0);
        expect_at(t + 2, 2, 0);
        tick();
        wr_if.iWrReq = 1'b0;
        repeat (3) tick();
        cmp("mem0_written", cyc, 16'(mem[0]), 16'h00E0);

        // Display fetch of cell 82 then 83, pixel replicated 8 wide, 0 after active area
        tick(); t = cyc;
        expect_at(t + 1, 3, 82);
        expect_at(t + 1, 2, 0);
        expect_at(t + 2, 5, 0);
        for (int k = 3; k <= 10; k++) expect_at(t + k, 5, 'h1C);
        expect_at(t + 9, 3, 83);
        expect_at(t + 11, 5, 'h55);
        expect_at(t + 12, 5, 0);
        for (int i = 0; i <= 8; i++) begin
            cnt_h = 10'(16 + i);
            cnt_v = 10'd8;
            tick();
        end
        blank();
        repeat (4) tick();

`ifdef VGA_FB_BLANK_WRITE_EN
        // Request during active lines waits for the first blanking line
        tick(); t = cyc;
        cnt_v = 10'd100;
        request(100, 'h3A);
        expect_at(t + 1, 0, 0);
        expect_at(t + 2, 0, 0);
        expect_at(t + 3, 0, 0);
        expect_at(t + 4, 0, 1);
        expect_ack(100, 1'b1, 'h3A, 1'b0);
        repeat (3) tick();
        cnt_v = 10'd480;
        tick();
        wr_if.iWrReq = 1'b0;
        blank();
        repeat (2) tick();
`else
        // Collision: request in a slot cycle loses to the fetch, acked one cycle later
        tick(); t = cyc;
        cnt_h = 10'd8;
        cnt_v = 10'd0;
        request(100, 'h3A);
        expect_at(t + 1, 3, 1);
        expect_at(t + 1, 2, 0);
        expect_at(t + 1, 0, 0);
        expect_at(t + 2, 0, 1);
        expect_at(t + 2, 3, 100);
        expect_at(t + 2, 2, 1);
        expect_ack(100, 1'b1, 'h3A, 1'b0);
        tick();
        cnt_h = 10'd9;
        tick();
        wr_if.iWrReq = 1'b0;
        blank();
        repeat (2) tick();
`endif
        cmp("mem100_written", cyc, 16'(mem[100]), 16'h003A);

        // Out of range address: acked with error, nothing written
        tick(); t = cyc;
        request(4800, 'h77);
        expect_ack(4800, 1'b0, 'h77, 1'b1);
        expect_at(t + 1, 1, 1);
        expect_at(t + 1, 2, 0);
        expect_at(t + 2, 1, 0);
        tick();
        wr_if.iWrReq = 1'b0;
        repeat (3) tick();
        cmp("mem4800_untouched", cyc, 16'(mem[4800]), 16'h0000);

        // Reset during the write cycle: outputs clear at once, write re-granted once after release
        tick(); t = cyc;
        request(5, 'h99);
        expect_at(t + 1, 0, 0);
        expect_at(t + 1, 2, 0);
        expect_at(t + 1, 5, 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        cmp("mem5_not_committed", cyc, 16'(mem[5]), 16'h0000);
        rst = 1'b0;
        expect_ack(5, 1'b1, 'h99, 1'b0);
        expect_at(t + 4, 0, 1);
        expect_at(t + 4, 2, 1);
        expect_at(t + 5, 0, 0);
        tick();
        wr_if.iWrReq = 1'b0;
        repeat (3) tick();
        cmp("mem5_written", cyc, 16'(mem[5]), 16'h0099);

        repeat (3) tick();
        cmp("acks_outstanding", cyc, 16'(ack_q.size()), 16'd0);
        cmp("checks_outstanding", cyc, 16'(chk_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
